// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single data-memory port between the CPU data interface and the
//   DMA engine. The CPU normally has priority. The DMA is served when the CPU
//   is idle, when it has been refused MAX_WAIT times in a row, or for a short
//   locked burst of up to MAX_BURST grants. The grant is decided
//   combinationally in the cycle of the request. The memory behind this block
//   is clocked on the falling edge, so read data comes back in the grant
//   cycle.
//
// Ports
//   sys_clk, rst_sync       clock (rising edge), asynchronous active-high reset
//   cpu_ce/wbe/addr/wdata   CPU request; cpu_wbe == 0 means a read
//   cpu_rdata, cpu_wait     CPU read data, request refused this cycle
//   dma_req/lock/we/addr/wdata  DMA request, burst lock, word write
//   dma_rdata, dma_gnt      DMA read data, DMA served this cycle
//   mem_ce/wbe/addr/wdata   memory-side request
//   mem_rdata               memory read data
//   conflict_cnt            saturating count of cycles with cpu_wait = 1
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_sync,
  input  logic                  cpu_ce,
  input  logic [3:0]            cpu_wbe,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_wait,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_gnt,
  output logic                  mem_ce,
  output logic [3:0]            mem_wbe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           conflict_cnt
);

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  typedef enum logic {NORMAL = 1'b0, LOCK = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]  burst_cnt, burst_cnt_nxt;
  logic        cool, cool_nxt;
  logic [15:0] conflict_q, conflict_nxt;
  logic        cpu_gnt, dma_gnt_i;

  function automatic logic [3:0] sat_inc_wait(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc_conflict(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register
  always_ff @(posedge sys_clk or posedge rst_sync) begin
    if (rst_sync) begin
      state      <= NORMAL;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      cool       <= 1'b0;
      conflict_q <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      burst_cnt  <= burst_cnt_nxt;
      cool       <= cool_nxt;
      conflict_q <= conflict_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    cool_nxt      = 1'b0;
    conflict_nxt  = cpu_wait ? sat_inc_conflict(conflict_q) : conflict_q;
    // A refused DMA request ages; any grant or a dropped request clears it.
    wait_cnt_nxt  = (dma_req && !dma_gnt_i) ? sat_inc_wait(wait_cnt, MAX_WAIT_C) : 4'd0;
    case (state)
      NORMAL: begin
        // cool keeps the cycle after a full burst for the CPU.
        if (dma_gnt_i && dma_lock && !cool) begin
          state_nxt     = LOCK;
          burst_cnt_nxt = 8'd1;
        end
      end
      LOCK: begin
        if (dma_gnt_i) burst_cnt_nxt = burst_cnt + 8'd1;
        if (dma_gnt_i && burst_cnt == MAX_BURST_C) begin
          state_nxt = NORMAL;
          cool_nxt  = 1'b1;
        end else if (!dma_req || !dma_lock) begin
          state_nxt = NORMAL;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Grant decision and memory-port mux
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_i = 1'b0;
    if (!rst_sync) begin
      if (state == LOCK) begin
        if (dma_req)     dma_gnt_i = 1'b1;
        else if (cpu_ce) cpu_gnt   = 1'b1;
      end else begin
        if (dma_req && wait_cnt == MAX_WAIT_C) dma_gnt_i = 1'b1;
        else if (cpu_ce)                       cpu_gnt   = 1'b1;
        else if (dma_req)                      dma_gnt_i = 1'b1;
      end
    end
    dma_gnt      = dma_gnt_i;
    cpu_wait     = cpu_ce & ~cpu_gnt & ~rst_sync;
    mem_ce       = cpu_gnt | dma_gnt_i;
    mem_wbe      = cpu_gnt ? cpu_wbe : (dma_gnt_i ? {4{dma_we}} : 4'b0000);
    // Address and data follow the CPU unless the DMA owns the port.
    mem_addr     = dma_gnt_i ? dma_addr  : cpu_addr;
    mem_wdata    = dma_gnt_i ? dma_wdata : cpu_wdata;
    cpu_rdata    = mem_rdata;
    dma_rdata    = mem_rdata;
    conflict_cnt = rst_sync ? 16'h0000 : conflict_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce = 1'b0;
  logic [3:0]  cpu_wbe = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_wait;
  logic        dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
  logic        dma_gnt;
  logic        mem_ce;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .sys_clk(clk), .rst_sync(rst),
    .cpu_ce(cpu_ce), .cpu_wbe(cpu_wbe), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
    .mem_ce(mem_ce), .mem_wbe(mem_wbe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Falling-edge data memory, 256 words
  logic [31:0] mem_arr [256] = '{default: 32'h0};
  always @(negedge clk) begin
    if (mem_ce) begin
      mem_rdata <= mem_arr[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    bit          rst;
    bit          gnt_dma;
    bit          cwait;
    bit          ce;
    logic [3:0]  wbe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] confl;
    bit          chk_crd;
    bit          chk_drd;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] shadow [256] = '{default: 32'h0};
  bit m_locked = 0;
  int m_denied = 0;
  int m_bursts = 0;
  bit m_cool = 0;
  int m_confl = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic apply(input bit r, input bit cce, input logic [3:0] cwbe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input bit dreq, input bit dlock, input bit dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    exp_t e;
    int who;
    bit limit;
    @(posedge clk);
    #1;
    rst = r; cpu_ce = cce; cpu_wbe = cwbe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_lock = dlock; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    e = '{default: 0};
    if (r) begin
      m_locked = 0; m_denied = 0; m_bursts = 0; m_cool = 0; m_confl = 0;
      e.rst = 1;
    end else begin
      if (m_locked) who = dreq ? 2 : (cce ? 1 : 0);
      else if (dreq && m_denied == MAX_WAIT) who = 2;
      else if (cce) who = 1;
      else if (dreq) who = 2;
      else who = 0;
      e.gnt_dma = (who == 2);
      e.cwait   = cce && (who != 1);
      e.ce      = (who != 0);
      e.wbe     = (who == 1) ? cwbe : ((who == 2) ? {4{dwe}} : 4'b0000);
      e.addr    = (who == 2) ? daddr : caddr;
      e.wdata   = (who == 2) ? dwd : cwd;
      e.confl   = 16'(m_confl);
      if (who == 1) begin
        if (cwbe == 4'b0000) begin
          e.chk_crd = 1; e.rdata = shadow[caddr[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (cwbe[b]) shadow[caddr[9:2]][8*b +: 8] = cwd[8*b +: 8];
        end
      end else if (who == 2) begin
        if (!dwe) begin
          e.chk_drd = 1; e.rdata = shadow[daddr[9:2]];
        end else begin
          shadow[daddr[9:2]] = dwd;
        end
      end
      // Advance the model to the next cycle
      if (e.cwait && m_confl < 65535) m_confl++;
      if (dreq && who != 2) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
      else m_denied = 0;
      if (!m_locked) begin
        if (who == 2 && dlock && !m_cool) begin
          m_locked = 1; m_bursts = 1;
        end
        m_cool = 0;
      end else begin
        limit = (who == 2) && (m_bursts == MAX_BURST);
        if (who == 2) m_bursts++;
        if (limit || !dreq || !dlock) m_locked = 0;
        m_cool = limit;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: compares one expectation per cycle, after the memory has answered
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dma_gnt", 32'(dma_gnt), 32'(e.gnt_dma));
        chk("cpu_wait", 32'(cpu_wait), 32'(e.cwait));
        chk("mem_ce", 32'(mem_ce), 32'(e.ce));
        chk("mem_wbe", 32'(mem_wbe), 32'(e.wbe));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(e.confl));
        if (!e.rst) begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        if (e.chk_crd) chk("cpu_rdata", cpu_rdata, e.rdata);
        if (e.chk_drd) chk("dma_rdata", dma_rdata, e.rdata);
      end
    end
  end

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    return a;
  endfunction

  initial begin
    // Reset with both requesters active
    repeat (2) apply(1, 1, 4'h0, 32'h10, 32'h0, 1, 1, 1, 32'h40, 32'h1);
    // First cycle after release goes to the CPU
    apply(0, 1, 4'h0, 32'h10, 32'h0, 1, 0, 0, 32'h44, 32'h0);
    // CPU partial write then read back
    apply(0, 1, 4'b0011, 32'h10, 32'h0000A5A5, 0, 0, 0, 32'h0, 32'h0);
    apply(0, 1, 4'b0000, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    // DMA steals an idle cycle
    apply(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'h40, 32'hDEADBEEF);
    apply(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h40, 32'h0);
    // Starvation override without lock
    apply(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      apply(0, 1, 4'h0, raddr(), 32'h0, 1, 0, 0, raddr(), 32'h0);
    // Locked bursts limited by MAX_BURST
    for (int i = 0; i < 30; i++)
      apply(0, 1, 4'h0, raddr(), 32'h0, 1, 1, 1, raddr(), $urandom);
    // Lock dropped at the third burst cycle
    apply(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      apply(0, 1, 4'h0, raddr(), 32'h0, 1, (i != 6), 0, raddr(), 32'h0);
    // Reset in the middle of a burst
    apply(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++)
      apply(0, 1, 4'h0, raddr(), 32'h0, 1, 1, 0, raddr(), 32'h0);
    apply(1, 1, 4'h0, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
    apply(0, 1, 4'h0, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w, raddr(), $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            raddr(), $urandom);
    end
    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #8;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
